// File: rtl/pixel_ops_pkg.sv
// rtl/pixel_ops_pkg.sv - shared widths, operation codes and pixel limits for the point-op engine
package pixel_ops_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] PIX_MAX = 8'd255;
    localparam logic [DATA_W-1:0] PIX_MIN = 8'd0;

    typedef enum logic [1:0] {
        OP_BRIGHTEN = 2'b00,
        OP_DARKEN   = 2'b01,
        OP_THRESH   = 2'b10,
        OP_INVERT   = 2'b11
    } pixel_op_e;

endpackage

// File: rtl/pixel_alu.sv
// rtl/pixel_alu.sv - combinational per-pixel operation datapath
module pixel_alu
    import pixel_ops_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [1:0]   op_i,
    input  logic [W-1:0] pixel_i,
    input  logic [W-1:0] value_i,
    input  logic [W-1:0] threshold_i,
    output logic [W-1:0] result_o
);

    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W-1:0] all_ones;
    pixel_op_e    op;

    assign op       = pixel_op_e'(op_i);
    assign all_ones = {W{1'b1}};

    // One extra bit exposes carry (add) or borrow (subtract) for saturation.
    assign sum  = {1'b0, pixel_i} + {1'b0, value_i};
    assign diff = {1'b0, pixel_i} - {1'b0, value_i};

    always_comb begin
        result_o = '0;
        unique case (op)
            OP_BRIGHTEN: result_o = sum[W]  ? all_ones : sum[W-1:0];
            OP_DARKEN:   result_o = diff[W] ? '0       : diff[W-1:0];
            OP_THRESH:   result_o = (pixel_i >= threshold_i) ? all_ones : '0;
            OP_INVERT:   result_o = ~pixel_i;
            default:     result_o = '0;
        endcase
    end

endmodule

// File: rtl/pixel_point_op.sv
// rtl/pixel_point_op.sv - registered point-operation engine, one pixel per clock
module pixel_point_op
    import pixel_ops_pkg::*;
#(
    parameter int DATA_W = pixel_ops_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        select,
    input  logic [DATA_W-1:0] value,
    input  logic [DATA_W-1:0] threshold,
    input  logic [DATA_W-1:0] inbyte,
    output logic [DATA_W-1:0] outbyte
);

    logic [DATA_W-1:0] outbyte_d;
    logic [DATA_W-1:0] outbyte_q;

    pixel_alu #(
        .W (DATA_W)
    ) u_alu (
        .op_i        (select),
        .pixel_i     (inbyte),
        .value_i     (value),
        .threshold_i (threshold),
        .result_o    (outbyte_d)
    );

    // Operands are sampled alongside the pixel; no mode is held between pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outbyte_q <= '0;
        end else begin
            outbyte_q <= outbyte_d;
        end
    end

    assign outbyte = outbyte_q;

endmodule

// File: tb/tb_pixel_point_op.sv
// tb/tb_pixel_point_op.sv - directed self-checking bench with a behavioural pixel model
module tb_pixel_point_op;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] select = 2'b11;
    logic [7:0] value = 8'h00;
    logic [7:0] threshold = 8'h00;
    logic [7:0] inbyte = 8'h00;
    logic [7:0] outbyte;

    int n_pass = 0;
    int n_total = 0;
    int exp_out = 0;

    pixel_point_op dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .select    (select),
        .value     (value),
        .threshold (threshold),
        .inbyte    (inbyte),
        .outbyte   (outbyte)
    );

    always #5 clk = ~clk;

    function automatic int model(input int sel, input int v, input int t, input int p);
        int r;
        case (sel)
            0: r = (p + v > 255) ? 255 : p + v;
            1: r = (p - v < 0) ? 0 : p - v;
            2: r = (p >= t) ? 255 : 0;
            default: r = 255 - p;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input int actual, input int required);
        n_total++;
        if (actual == required) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, required, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_out = 0;
        else exp_out = model(int'(select), int'(value), int'(threshold), int'(inbyte));
    end

    always @(negedge clk) begin
        check("model_compare", int'(outbyte), exp_out);
    end

    task automatic apply(input string name, input logic [1:0] s, input logic [7:0] v,
                         input logic [7:0] t, input logic [7:0] p, input int required);
        @(negedge clk);
        #1;
        select = s; value = v; threshold = t; inbyte = p;
        @(posedge clk);
        #1;
        check(name, int'(outbyte), required);
    endtask

    initial begin
        check("model_mode_brighten", model(0, 8'h40, 8'h82, 8'h80), 8'hC0);
        check("model_mode_darken",   model(1, 8'h40, 8'h82, 8'h80), 8'h40);
        check("model_mode_thresh",   model(2, 8'h40, 8'h82, 8'h80), 8'h00);
        check("model_mode_invert",   model(3, 8'h40, 8'h82, 8'h80), 8'h7F);

        select = 2'b11; inbyte = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", int'(outbyte), 8'h00);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_first", int'(outbyte), 8'h55);

        apply("inv_00", 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);
        apply("inv_0f", 2'b11, 8'h00, 8'h00, 8'h0F, 8'hF0);
        apply("inv_ff", 2'b11, 8'h00, 8'h00, 8'hFF, 8'h00);
        apply("inv_82", 2'b11, 8'h00, 8'h00, 8'h82, 8'h7D);

        apply("bright_10", 2'b00, 8'h40, 8'h00, 8'h10, 8'h50);
        apply("dark_10",   2'b01, 8'h40, 8'h00, 8'h10, 8'h00);
        apply("bright_c8", 2'b00, 8'h40, 8'h00, 8'hC8, 8'hFF);
        apply("dark_c8",   2'b01, 8'h40, 8'h00, 8'hC8, 8'h88);
        apply("bright_ff", 2'b00, 8'h40, 8'h00, 8'hFF, 8'hFF);
        apply("dark_ff",   2'b01, 8'h40, 8'h00, 8'hFF, 8'hBF);
        apply("bright_v0", 2'b00, 8'h00, 8'h00, 8'h9C, 8'h9C);
        apply("dark_v0",   2'b01, 8'h00, 8'h00, 8'h9C, 8'h9C);
        apply("dark_0",    2'b01, 8'hFF, 8'h00, 8'h00, 8'h00);
        apply("bright_ff_ff", 2'b00, 8'hFF, 8'h00, 8'hFF, 8'hFF);

        apply("thr_81", 2'b10, 8'h00, 8'h82, 8'h81, 8'h00);
        apply("thr_82", 2'b10, 8'h00, 8'h82, 8'h82, 8'hFF);
        apply("thr_fe", 2'b10, 8'h00, 8'h82, 8'hFE, 8'hFF);
        apply("thr_t0", 2'b10, 8'h00, 8'h00, 8'h00, 8'hFF);

        apply("switch_00", 2'b00, 8'h40, 8'h82, 8'h80, 8'hC0);
        apply("switch_01", 2'b01, 8'h40, 8'h82, 8'h80, 8'h40);
        apply("switch_10", 2'b10, 8'h40, 8'h82, 8'h80, 8'h00);
        apply("switch_11", 2'b11, 8'h40, 8'h82, 8'h80, 8'h7F);

        apply("pre_async_inv", 2'b11, 8'h00, 8'h00, 8'h0F, 8'hF0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_no_edge", int'(outbyte), 8'h00);
        @(posedge clk);
        #1;
        check("async_reset_held", int'(outbyte), 8'h00);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        apply("post_async_inv", 2'b11, 8'h00, 8'h00, 8'h82, 8'h7D);

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            select    = 2'($urandom_range(0, 3));
            value     = 8'($urandom_range(0, 255));
            threshold = 8'($urandom_range(0, 255));
            inbyte    = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
